// File: rtl/scanline_emu_param_if.sv
// scanline_emu_param_if: video stream and scanline config bundle for scanline_emu_param
interface scanline_emu_param_if #(
  parameter int COLOR_W = 8,
  parameter int N_CH    = 3
);
  logic                   HSYNC_i;
  logic                   VSYNC_i;
  logic                   DE_i;
  logic [N_CH*COLOR_W-1:0] vdata_i;
  logic                   sl_en_i;
  logic                   sl_per_channel_i;
  logic [1:0]             sl_thickness_i;
  logic [1:0]             sl_profile_i;
  logic [7:0]             sl_rel_pos_i;
  logic [7:0]             sl_strength_i;
  logic [4:0]             sl_bloom_i;
  logic                   HSYNC_o;
  logic                   VSYNC_o;
  logic                   DE_o;
  logic [N_CH*COLOR_W-1:0] vdata_o;
  modport master (
    output HSYNC_i, VSYNC_i, DE_i, vdata_i, sl_en_i, sl_per_channel_i,
           sl_thickness_i, sl_profile_i, sl_rel_pos_i, sl_strength_i, sl_bloom_i,
    input  HSYNC_o, VSYNC_o, DE_o, vdata_o
  );
  modport slave (
    input  HSYNC_i, VSYNC_i, DE_i, vdata_i, sl_en_i, sl_per_channel_i,
           sl_thickness_i, sl_profile_i, sl_rel_pos_i, sl_strength_i, sl_bloom_i,
    output HSYNC_o, VSYNC_o, DE_o, vdata_o
  );
endinterface

// File: rtl/scanline_emu_param.sv
// scanline_emu_param: 6-stage scanline darkening with profile weight and bloom, N_CH x COLOR_W pixels.
// Define SL_CFG_SHADOW_EN to latch sl_* config (except rel_pos) only at VSYNC_i falling edges.
module scanline_emu_param #(
  parameter int COLOR_W = 8,
  parameter int N_CH    = 3
) (
  input logic                 VCLK_i,
  input logic                 nVRST_i,
  scanline_emu_param_if.slave bus
);
  localparam int W = N_CH * COLOR_W;
  logic [5:0]   r_hs, r_vs, r_de;
  logic [W-1:0] r_vd1, r_vd2, r_vd3, r_vd4, r_vd5, w_vdo;
  logic [7:0]   r_pos1;
  logic [6:0]   r_d2;
  logic         r_en1, r_en2, r_en3, r_en4, r_en5, r_pc1;
  logic [1:0]   r_thk1, r_thk2, r_prof1, r_prof2, r_prof3;
  logic [7:0]   r_str1, r_str2, r_str3, r_str4;
  logic [4:0]   r_blm1, r_blm2, r_blm3, w_b;
  logic [7:0]   w_max;
  logic         w_cfg_ld;
`ifdef SL_CFG_SHADOW_EN
  logic r_vs_prev;
  always_ff @(posedge VCLK_i or negedge nVRST_i)
    if (!nVRST_i) r_vs_prev <= 1'b1;
    else          r_vs_prev <= bus.VSYNC_i;
  assign w_cfg_ld = r_vs_prev & ~bus.VSYNC_i;
`else
  assign w_cfg_ld = 1'b1;
`endif
  always_comb begin
    w_max = '0;
    for (int k = 0; k < N_CH; k++)
      w_max = (r_vd1[k*COLOR_W+COLOR_W-8 +: 8] > w_max) ? r_vd1[k*COLOR_W+COLOR_W-8 +: 8] : w_max;
  end
  assign w_b = (r_blm3 > 5'd25) ? 5'd25 : r_blm3;
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      r_hs    <= '1;
      r_vs    <= '1;
      r_de    <= '0;
      r_vd1   <= '0;
      r_vd2   <= '0;
      r_vd3   <= '0;
      r_vd4   <= '0;
      r_vd5   <= '0;
      r_pos1  <= '0;
      r_d2    <= '0;
      r_en1   <= 1'b0;
      r_en2   <= 1'b0;
      r_en3   <= 1'b0;
      r_en4   <= 1'b0;
      r_en5   <= 1'b0;
      r_pc1   <= 1'b0;
      r_thk1  <= '0;
      r_thk2  <= '0;
      r_prof1 <= '0;
      r_prof2 <= '0;
      r_prof3 <= '0;
      r_str1  <= '0;
      r_str2  <= '0;
      r_str3  <= '0;
      r_str4  <= '0;
      r_blm1  <= '0;
      r_blm2  <= '0;
      r_blm3  <= '0;
    end else begin
      r_hs   <= {r_hs[4:0], bus.HSYNC_i};
      r_vs   <= {r_vs[4:0], bus.VSYNC_i};
      r_de   <= {r_de[4:0], bus.DE_i};
      r_vd1  <= bus.vdata_i;
      r_vd2  <= r_vd1;
      r_vd3  <= r_vd2;
      r_vd4  <= r_vd3;
      r_vd5  <= r_vd4;
      r_pos1 <= bus.sl_rel_pos_i;
      if (w_cfg_ld) begin
        r_en1   <= bus.sl_en_i;
        r_pc1   <= bus.sl_per_channel_i;
        r_thk1  <= bus.sl_thickness_i;
        r_prof1 <= bus.sl_profile_i;
        r_str1  <= bus.sl_strength_i;
        r_blm1  <= bus.sl_bloom_i;
      end
      r_d2    <= r_pos1[7] ? ~r_pos1[6:0] : r_pos1[6:0];
      r_en2   <= r_en1;
      r_en3   <= r_en2;
      r_en4   <= r_en3;
      r_en5   <= r_en4;
      r_thk2  <= r_thk1;
      r_prof2 <= r_prof1;
      r_prof3 <= r_prof2;
      r_str2  <= r_str1;
      r_str3  <= r_str2;
      r_str4  <= r_str3;
      r_blm2  <= r_blm1;
      r_blm3  <= r_blm2;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [7:0]         r_l2, r_l3, r_x3, r_w4, r_a5;
    logic               r_in3;
    logic [8:0]         r_r4;
    logic [COLOR_W-1:0] r_o;
    logic [1:0]         w_t;
    logic               w_in;
    logic [7:0]         w_x, w_xi, w_hann, w_gaus, w_flat, w_w, w_s, w_a;
    logic [8:0]         w_br, w_r;
    logic [COLOR_W-1:0] w_c, w_o;
    // thickness code doubles as the shift: h = 16<<t, x = d<<(4-t)
    assign w_t    = (r_thk2 != 2'd0) ? r_thk2 :
                    (r_l2 >= 8'd171) ? 2'd1 : (r_l2 >= 8'd86) ? 2'd2 : 2'd3;
    assign w_in   = {1'b0, r_d2} < (8'd16 << w_t);
    assign w_x    = 8'({3'b0, r_d2} << (3'd4 - {1'b0, w_t}));
    assign w_xi   = ~r_x3;
    assign w_hann = 8'd255 - 8'((16'(r_x3) * 16'(r_x3)) >> 8);
    assign w_gaus = 8'((16'(w_xi) * 16'(w_xi)) >> 8);
    assign w_flat = r_x3[7] ? {w_xi[6:0], 1'b0} : 8'd255;
    assign w_w    = !r_in3 ? 8'd0 : (r_prof3 == 2'd2) ? 8'd255 : (r_prof3 == 2'd3) ? w_flat :
                    (r_prof3 == 2'd0) ? w_hann : w_gaus;
    assign w_br   = 9'((13'(w_b) * 13'(r_l3)) >> 4);
    assign w_r    = (w_br > 9'd256) ? 9'd256 : w_br;
    assign w_s    = 8'((16'(r_str4) * 16'(r_w4)) >> 8);
    assign w_a    = 8'((17'(w_s) * 17'(9'd256 - r_r4)) >> 8);
    assign w_c    = r_vd5[i*COLOR_W +: COLOR_W];
    assign w_o    = r_en5 ? w_c - COLOR_W'(((COLOR_W+8)'(w_c) * (COLOR_W+8)'(r_a5)) >> 8) : w_c;
    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
      if (!nVRST_i) begin
        r_l2  <= '0;
        r_l3  <= '0;
        r_x3  <= '0;
        r_in3 <= 1'b0;
        r_w4  <= '0;
        r_r4  <= '0;
        r_a5  <= '0;
        r_o   <= '0;
      end else begin
        r_l2  <= r_pc1 ? r_vd1[i*COLOR_W+COLOR_W-8 +: 8] : w_max;
        r_l3  <= r_l2;
        r_x3  <= w_in ? w_x : 8'd0;
        r_in3 <= w_in;
        r_w4  <= w_w;
        r_r4  <= w_r;
        r_a5  <= w_a;
        r_o   <= w_o;
      end
    end
    assign w_vdo[i*COLOR_W +: COLOR_W] = r_o;
  end
  assign bus.HSYNC_o = r_hs[5];
  assign bus.VSYNC_o = r_vs[5];
  assign bus.DE_o    = r_de[5];
  assign bus.vdata_o = w_vdo;
endmodule

// File: tb/tb_scanline_emu_param.sv
// tb_scanline_emu_param: scoreboard bench driving 3x8 and 4x10 instances from one stimulus stream.
module tb_scanline_emu_param;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  scanline_emu_param_if #(.COLOR_W(8),  .N_CH(3)) b0 ();
  scanline_emu_param_if #(.COLOR_W(10), .N_CH(4)) b1 ();
  scanline_emu_param #(.COLOR_W(8),  .N_CH(3)) u0 (.VCLK_i(clk), .nVRST_i(rst_n), .bus(b0.slave));
  scanline_emu_param #(.COLOR_W(10), .N_CH(4)) u1 (.VCLK_i(clk), .nVRST_i(rst_n), .bus(b1.slave));
  typedef struct {
    logic en, pc;
    logic [1:0] thk, prof;
    logic [7:0] str;
    logic [4:0] blm;
  } cfg_t;
  typedef struct {
    int due;
    logic hs, vs, de;
    logic [23:0] v0;
    logic [39:0] v1;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int cyc = 0, checks = 0, errors = 0;
  cfg_t shadow;
  logic prev_vs;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int model_ch(int c, int L, cfg_t k, int p);
    int d, t, h, sh, x, w, b, s, r, a;
    d  = (p < 128) ? p : 255 - p;
    t  = (k.thk != 0) ? int'(k.thk) : (L >= 171) ? 1 : (L >= 86) ? 2 : 3;
    h  = (t == 1) ? 32 : (t == 2) ? 64 : 128;
    sh = (t == 1) ? 3 : (t == 2) ? 2 : 1;
    if (d >= h) w = 0;
    else begin
      x = d << sh;
      case (k.prof)
        2'd2:    w = 255;
        2'd3:    w = (x < 128) ? 255 : (255 - x) * 2;
        2'd0:    w = 255 - ((x * x) >> 8);
        default: w = ((255 - x) * (255 - x)) >> 8;
      endcase
    end
    s = (int'(k.str) * w) >> 8;
    b = (k.blm > 25) ? 25 : int'(k.blm);
    r = (b * L) >> 4;
    if (r > 256) r = 256;
    a = (s * (256 - r)) >> 8;
    return k.en ? c - ((c * a) >> 8) : c;
  endfunction
  function automatic logic [47:0] model(logic [47:0] vd, int cw, int nch, cfg_t k, int p);
    int c[4], c8[4], mx;
    logic [47:0] res, mask;
    mask = (48'd1 << cw) - 48'd1;
    mx = 0;
    res = '0;
    for (int i = 0; i < nch; i++) begin
      c[i]  = int'((vd >> (i * cw)) & mask);
      c8[i] = c[i] >> (cw - 8);
      if (c8[i] > mx) mx = c8[i];
    end
    for (int i = 0; i < nch; i++)
      res = res | (48'(model_ch(c[i], k.pc ? c8[i] : mx, k, p)) << (i * cw));
    return res;
  endfunction
  task automatic chk(input string n, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      m = q.pop_front();
      chk("missed_output", 48'(cyc), 48'(m.due));
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      m = q.pop_front();
      chk("hsync", 48'(b0.HSYNC_o), 48'(m.hs));
      chk("vsync", 48'(b0.VSYNC_o), 48'(m.vs));
      chk("de", 48'(b0.DE_o), 48'(m.de));
      chk("vdata_3x8", 48'(b0.vdata_o), 48'(m.v0));
      chk("sync_4x10", 48'({b1.HSYNC_o, b1.VSYNC_o, b1.DE_o}), 48'({m.hs, m.vs, m.de}));
      chk("vdata_4x10", 48'(b1.vdata_o), 48'(m.v1));
    end
  end
  // drives one pixel (caller is at a negedge), records its expectation, advances to the next negedge
  task automatic step(input logic hs, input logic vs, input logic de, input logic [39:0] vd,
                      input cfg_t k, input logic [7:0] p, input bit ho = 1'b0, input logic [23:0] ov = '0);
    exp_t e;
    cfg_t u;
    {b0.HSYNC_i, b0.VSYNC_i, b0.DE_i} = {hs, vs, de};
    {b1.HSYNC_i, b1.VSYNC_i, b1.DE_i} = {hs, vs, de};
    b0.vdata_i = vd[23:0];
    b1.vdata_i = vd;
    {b0.sl_en_i, b0.sl_per_channel_i, b0.sl_thickness_i, b0.sl_profile_i} = {k.en, k.pc, k.thk, k.prof};
    {b1.sl_en_i, b1.sl_per_channel_i, b1.sl_thickness_i, b1.sl_profile_i} = {k.en, k.pc, k.thk, k.prof};
    {b0.sl_strength_i, b0.sl_bloom_i, b0.sl_rel_pos_i} = {k.str, k.blm, p};
    {b1.sl_strength_i, b1.sl_bloom_i, b1.sl_rel_pos_i} = {k.str, k.blm, p};
`ifdef SL_CFG_SHADOW_EN
    if (prev_vs && !vs) shadow = k;
    prev_vs = vs;
    u = shadow;
`else
    u = k;
    if (ho) u.en = 1'b1;
`endif
    e.due = cyc + 6;
    {e.hs, e.vs, e.de} = {hs, vs, de};
    e.v0 = 24'(model(48'(vd[23:0]), 8, 3, u, int'(p)));
    e.v1 = 40'(model(48'(vd), 10, 4, u, int'(p)));
`ifndef SL_CFG_SHADOW_EN
    if (ho) e.v0 = ov;
`endif
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic do_reset();
    exp_t e;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_sync_3x8", 48'({b0.HSYNC_o, b0.VSYNC_o, b0.DE_o}), 48'(3'b110));
    chk("rst_vdata_3x8", 48'(b0.vdata_o), 48'd0);
    chk("rst_sync_4x10", 48'({b1.HSYNC_o, b1.VSYNC_o, b1.DE_o}), 48'(3'b110));
    chk("rst_vdata_4x10", 48'(b1.vdata_o), 48'd0);
    shadow = '{default: '0};
    prev_vs = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      e.due = cyc + i;
      {e.hs, e.vs, e.de} = 3'b110;
      e.v0 = '0;
      e.v1 = '0;
      q.push_back(e);
    end
  endtask
  function automatic cfg_t rnd_cfg();
    cfg_t k;
    k.en   = ($urandom_range(0, 3) != 0);
    k.pc   = 1'($urandom);
    k.thk  = 2'($urandom);
    k.prof = 2'($urandom);
    k.str  = 8'($urandom);
    k.blm  = 5'($urandom);
    return k;
  endfunction
  task automatic rnd_run(input int n);
    cfg_t k;
    k = rnd_cfg();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) k = rnd_cfg();
      step(1'($urandom), ($urandom_range(0, 15) != 0), 1'($urandom),
           {8'($urandom), 32'($urandom)}, k, 8'($urandom));
    end
  endtask
  cfg_t k0;
  initial begin
    {b0.HSYNC_i, b0.VSYNC_i, b0.DE_i, b0.vdata_i} = {3'b110, 24'd0};
    {b1.HSYNC_i, b1.VSYNC_i, b1.DE_i, b1.vdata_i} = {3'b110, 40'd0};
    {b0.sl_en_i, b0.sl_per_channel_i, b0.sl_thickness_i, b0.sl_profile_i} = '0;
    {b1.sl_en_i, b1.sl_per_channel_i, b1.sl_thickness_i, b1.sl_profile_i} = '0;
    {b0.sl_strength_i, b0.sl_bloom_i, b0.sl_rel_pos_i} = '0;
    {b1.sl_strength_i, b1.sl_bloom_i, b1.sl_rel_pos_i} = '0;
    @(negedge clk);
    do_reset();
    k0 = '{en: 1'b1, pc: 1'b1, thk: 2'd1, prof: 2'd2, str: 8'd207, blm: 5'd0};
    step(1, 1, 1, {16'h5a3c, 24'hc8c8c8}, k0, 8'd0,   1, 24'h282828);
    step(1, 1, 1, {16'h1234, 24'hc8c8c8}, k0, 8'd128, 1, 24'hc8c8c8);
    k0.thk = 2'd2;
    k0.prof = 2'd3;
    step(1, 1, 1, {16'hbeef, 24'hc8c8c8}, k0, 8'd24,  1, 24'h282828);
    step(1, 1, 1, {16'h0f0f, 24'hc8c8c8}, k0, 8'd40,  1, 24'h515151);
    k0 = '{en: 1'b1, pc: 1'b1, thk: 2'd1, prof: 2'd2, str: 8'd207, blm: 5'd16};
    step(1, 1, 1, {16'h7777, 24'hffffff}, k0, 8'd0,   1, 24'hffffff);
    step(1, 1, 1, {16'h4242, 24'hc8c8c8}, k0, 8'd0,   1, 24'ha5a5a5);
    k0 = '{en: 1'b1, pc: 1'b0, thk: 2'd0, prof: 2'd0, str: 8'd207, blm: 5'd0};
    step(1, 1, 1, {16'h9999, 24'h0a0afa}, k0, 8'd40,  1, 24'h0a0afa);
    k0 = '{en: 1'b0, pc: 1'b0, thk: 2'd2, prof: 2'd1, str: 8'd255, blm: 5'd0};
    for (int i = 0; i < 10; i++)
      step((i < 3) ? 1'b0 : 1'b1, 1'b1, (i == 5), {8'($urandom), 32'($urandom)}, k0, 8'($urandom));
    k0.en = 1'b1;
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b1, {8'($urandom), 32'($urandom)}, k0, 8'($urandom_range(0, 40)));
    for (int i = 0; i < 16; i++)
      step(1'b1, (i < 2) ? 1'b0 : 1'b1, 1'b0, {8'($urandom), 32'($urandom)}, k0, 8'($urandom_range(0, 40)));
    rnd_run(400);
    do_reset();
    rnd_run(400);
    repeat (10) @(negedge clk);
    chk("queue_drained", 48'(q.size()), 48'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
